// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default width.
// Build option SERIAL_ADDER_SUB_EN adds a subtract mode (see serial_adder_ctrl).
package serial_adder_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between the ALU sequencer (master) and the serial adder (slave).
// The sub request exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, carry_in, sub, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, sub, output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, carry_in, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, output busy, done, sum, carry_out);
`endif

endinterface

// File: rtl/hFullAdder.sv
// Single-bit full adder cell.
// Purely combinational, zero latency, no flow control.
module hFullAdder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic carry_out,
    output logic out
);

    assign out       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first.
// Latency WIDTH+1 cycles start-to-done; start is ignored while busy or done (no queueing).
// Build option SERIAL_ADDER_SUB_EN adds a sub request computing a - b.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_out;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    hFullAdder u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (c_q),
        .carry_out (fa_cout),
        .out       (fa_out)
    );

    // Subtraction as a + ~b + 1 reuses the adder unchanged.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1 : bus.carry_in;
`else
    assign b_load = bus.b;
    assign c_load = bus.carry_in;
`endif

    assign acc_next = {fa_out, acc[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= b_load;
            c_q  <= c_load;
            cnt  <= '0;
        end else if (state_q == RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            acc  <= acc_next;
            c_q  <= fa_cout;
            cnt  <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= acc_next;
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=16 and WIDTH=5.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(16)) if16 ();
    serial_adder_ctrl_if #(.WIDTH(5))  if5 ();

    serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    serial_adder_ctrl #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(if5));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] av,
                         input logic [15:0] bv, input logic cin, input logic subv);
        if (sel == 0) begin
            if16.start = st; if16.a = av; if16.b = bv; if16.carry_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
            if16.sub = subv;
`endif
        end else begin
            if5.start = st; if5.a = av[4:0]; if5.b = bv[4:0]; if5.carry_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
            if5.sub = subv;
`endif
        end
        if (subv && st) begin end
    endtask

    // One operation; returns {carry_out,sum} zero-extended, start-to-done latency,
    // busy cycle count and whether done dropped the following cycle.
    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic cin, input logic subv, output logic [16:0] res,
                          output int lat, output int bcnt, output logic one_wide);
        logic got;
        logic dn;
        got = 1'b0; lat = 0; bcnt = 0; res = '0;
        @(negedge clk);
        drive(sel, 1'b1, av, bv, cin, subv);
        @(posedge clk);
        #1 drive(sel, 1'b0, av, bv, cin, subv);
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            dn = (sel == 0) ? if16.done : if5.done;
            if ((sel == 0) ? if16.busy : if5.busy) bcnt++;
            if (dn) begin
                got = 1'b1;
                lat = n;
                res = (sel == 0) ? {if16.carry_out, if16.sum} : {11'b0, if5.carry_out, if5.sum};
            end
        end
        @(negedge clk);
        one_wide = (sel == 0) ? !if16.done : !if5.done;
    endtask

    logic [16:0] res;
    logic [16:0] exp17;
    int          lat;
    int          bcnt;
    logic        ow;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    initial begin
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        check("rst_busy", 64'(if16.busy), 64'd0);
        check("rst_done", 64'(if16.done), 64'd0);
        check("rst_sum", 64'(if16.sum), 64'd0);
        check("rst_cout", 64'(if16.carry_out), 64'd0);
        check("rst_sum5", 64'(if5.sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, res, lat, bcnt, ow);
        check("lat_1p1", 64'(lat), 64'd17);
        check("busy_1p1", 64'(bcnt), 64'd16);
        check("res_1p1", 64'(res), 64'h0_0002);
        check("onewide_1p1", 64'(ow), 64'd1);

        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, res, lat, bcnt, ow);
        check("res_ffff_p1", 64'(res), 64'h1_0000);
        run_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, res, lat, bcnt, ow);
        check("res_cin_only", 64'(res), 64'h0_0001);

        // start held high; a changes mid-RUN; second accept at edge k+18
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 5) if16.a = 16'hFFFF;
            if (n == 10) check("b2b_busy_mid", 64'(if16.busy), 64'd1);
            if (n == 16) check("b2b_nodone16", 64'(if16.done), 64'd0);
            if (n == 17) begin
                check("b2b_done1", 64'(if16.done), 64'd1);
                check("b2b_res1", 64'({if16.carry_out, if16.sum}), 64'h0_2345);
            end
            if (n == 18) begin
                check("b2b_idle18", 64'(if16.busy), 64'd0);
                check("b2b_done18", 64'(if16.done), 64'd0);
            end
            if (n == 19) begin
                check("b2b_run19", 64'(if16.busy), 64'd1);
                if16.start = 1'b0;
            end
            if (n == 35) begin
                check("b2b_done2", 64'(if16.done), 64'd1);
                check("b2b_res2", 64'({if16.carry_out, if16.sum}), 64'h1_1110);
            end
        end

        // asynchronous reset during RUN
        @(negedge clk);
        drive(0, 1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        @(posedge clk);
        #1 if16.start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 64'(if16.busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(if16.busy), 64'd0);
        check("arst_done", 64'(if16.done), 64'd0);
        check("arst_sum", 64'(if16.sum), 64'd0);
        check("arst_cout", 64'(if16.carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(if16.busy), 64'd0);
        run_op(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, res, lat, bcnt, ow);
        check("post_rst_res", 64'(res), 64'h0_1000);
        check("post_rst_lat", 64'(lat), 64'd17);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, res, lat, bcnt, ow);
        check("sub_5m7", 64'(res), 64'h0_FFFE);
        run_op(0, 16'h0007, 16'h0005, 1'b0, 1'b1, res, lat, bcnt, ow);
        check("sub_7m5", 64'(res), 64'h1_0002);
        run_op(1, 16'h0003, 16'h0004, 1'b1, 1'b1, res, lat, bcnt, ow);
        check("sub5_3m4", 64'(res), 64'h0_001F);
`endif

        run_op(1, 16'h001F, 16'h0001, 1'b0, 1'b0, res, lat, bcnt, ow);
        check("w5_wrap_res", 64'(res), 64'h0_0020);
        check("w5_lat", 64'(lat), 64'd6);
        check("w5_busy", 64'(bcnt), 64'd5);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            run_op(0, ra, rb, rc, 1'b0, res, lat, bcnt, ow);
            exp17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            check("rnd16_res", 64'(res), 64'(exp17));
            check("rnd16_lat", 64'(lat), 64'd17);
            check("rnd16_onewide", 64'(ow), 64'd1);
        end
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            run_op(1, ra, rb, rc, 1'b0, res, lat, bcnt, ow);
            exp17 = 17'({1'b0, ra[4:0]} + {1'b0, rb[4:0]} + 6'(rc));
            check("rnd5_res", 64'(res), 64'(exp17));
            check("rnd5_lat", 64'(lat), 64'd6);
            check("rnd5_onewide", 64'(ow), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
